// File: rtl/store_buffer_pkg.sv
// Shared constants for the store buffer and its DataMemory neighbour.
// Byte-to-word shift and default bus widths.
package store_buffer_pkg;
  localparam int WORD_LSB   = 2;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/store_buffer_if.sv
// CPU store/load path and DataMemory port bundled for the store buffer.
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_fwd;
  logic              mem_busy;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_busy, mem_read_data,
    output st_ready, ld_data, ld_fwd, mem_we, mem_address, mem_write_data
  );

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_busy, mem_read_data,
    input  st_ready, ld_data, ld_fwd, mem_we, mem_address, mem_write_data
  );
endinterface

// File: rtl/store_buffer_match.sv
// Finds the youngest valid buffered store whose word tag equals the load tag.
module sb_youngest_match #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 30
) (
  input  logic [DEPTH-1:0]            valid,
  input  logic [DEPTH-1:0][TAG_W-1:0] tags,
  input  logic [TAG_W-1:0]            ld_tag,
  input  logic [$clog2(DEPTH)-1:0]    rd_ptr,
  output logic                        hit,
  output logic [$clog2(DEPTH)-1:0]    idx
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] e;

  // Walk oldest (rd_ptr) to youngest; the last match seen is the youngest.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    e   = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      e = rd_ptr + PTR_W'(k);
      if (valid[e] && (tags[e] == ld_tag)) begin
        hit = 1'b1;
        idx = e;
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the CPU store path and single-port DataMemory,
// with store-to-load forwarding and load-priority port arbitration.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  store_buffer_if.slave          bus,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int TAG_W = ADDR_W - WORD_LSB;

  logic [PTR_W-1:0]            wr_ptr, rd_ptr;
  logic [ADDR_W-1:0]           addr_q [DEPTH];
  logic [DATA_W-1:0]           data_q [DEPTH];
  logic [DEPTH-1:0]            valid;
  logic [DEPTH-1:0][TAG_W-1:0] tags;
  logic                        hit;
  logic [PTR_W-1:0]            hit_idx;
  logic                        enq, drain;

  // Entry i is live when its distance from rd_ptr (mod DEPTH) is below count.
  always_comb begin
    valid = '0;
    tags  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      tags[i]  = addr_q[i][ADDR_W-1:WORD_LSB];
      valid[i] = {1'b0, PTR_W'(i) - rd_ptr} < count;
    end
  end

  sb_youngest_match #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_match (
    .valid  (valid),
    .tags   (tags),
    .ld_tag (bus.ld_addr[ADDR_W-1:WORD_LSB]),
    .rd_ptr (rd_ptr),
    .hit    (hit),
    .idx    (hit_idx)
  );

  always_comb begin
    empty              = (count == '0);
    bus.st_ready       = (count != (PTR_W+1)'(DEPTH));
    bus.ld_fwd         = bus.ld_valid & hit;
    bus.ld_data        = bus.ld_fwd ? data_q[hit_idx] : bus.mem_read_data;
    enq                = bus.st_valid & bus.st_ready;
    // A load miss owns the address port; a hit leaves it free for draining.
    drain              = !empty && !bus.mem_busy && !(bus.ld_valid && !bus.ld_fwd);
    bus.mem_we         = drain;
    bus.mem_write_data = data_q[rd_ptr];
    bus.mem_address    = drain ? addr_q[rd_ptr] : bus.ld_addr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq)   wr_ptr <= wr_ptr + 1'b1;
      if (drain) rd_ptr <= rd_ptr + 1'b1;
      unique case ({enq, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wr_ptr] <= bus.st_addr;
      data_q[wr_ptr] <= bus.st_data;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboarded bench for store_buffer: expected memory writes are queued as
// stores are accepted and popped as drains appear on the memory port.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       empty;
  logic [2:0] count;

  store_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .empty (empty),
    .count (count)
  );

  always #5 clk = ~clk;

  // DataMemory model: combinational read, synchronous write, preset on reset.
  logic [DW-1:0] mem [64];
  assign bus.mem_read_data = mem[bus.mem_address[7:2]];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hCAFE0000 + 32'(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_address[7:2]] <= bus.mem_write_data;
    end
  end

  logic [63:0] sb_q [$];
  logic [63:0] exp_w;
  int checks = 0;
  int errors = 0;
  int nwrites = 0;

  // Drains are observed mid-cycle; the write lands at the following edge.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.mem_we === 1'b1) begin
      nwrites++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL drain_unexpected addr=%h data=%h required no write",
                 bus.mem_address, bus.mem_write_data);
      end else begin
        exp_w = sb_q.pop_front();
        if ({bus.mem_address, bus.mem_write_data} !== exp_w) begin
          errors++;
          $display("FAIL drain_order got %h/%h required %h/%h",
                   bus.mem_address, bus.mem_write_data, exp_w[63:32], exp_w[31:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
    if (bus.st_ready === 1'b1) sb_q.push_back({a, d});
    step();
    bus.st_valid = 1'b0;
  endtask

  task automatic drain_all();
    int n;
    bus.mem_busy = 1'b0;
    bus.ld_valid = 1'b0;
    n = 0;
    while (empty !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_timeout count=%0d required 0", count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.mem_busy = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d required 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b required 1", empty); end
    checks++; if (bus.st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready got %b required 1", bus.st_ready); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b required 0", bus.mem_we); end
    step();
    step();
    reset = 1'b0;
    checks++; if (bus.ld_fwd !== 1'b0) begin errors++; $display("FAIL idle_ld_fwd got %b required 0", bus.ld_fwd); end
  endtask

  task automatic test_single_store();
    do_store(32'h10, 32'hDEADBEEF);
    checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL single_we got %b required 1", bus.mem_we); end
    checks++; if (bus.mem_address !== 32'h10) begin errors++; $display("FAIL single_addr got %h required 00000010", bus.mem_address); end
    checks++; if (bus.mem_write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got %h required deadbeef", bus.mem_write_data); end
    step();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty got %b required 1", empty); end
    checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_mem got %h required deadbeef", mem[4]); end
  endtask

  task automatic test_full();
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) do_store(32'(i * 4), 32'h100 + 32'(i));
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d required 4", count); end
    checks++; if (bus.st_ready !== 1'b0) begin errors++; $display("FAIL full_st_ready got %b required 0", bus.st_ready); end
    do_store(32'h3C, 32'h555);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_held got %0d required 4", count); end
    bus.mem_busy = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.mem_we !== 1'b1 || bus.mem_address !== 32'(i * 4)) begin
        errors++;
        $display("FAIL full_drain%0d we=%b addr=%h required 1/%h", i, bus.mem_we, bus.mem_address, 32'(i * 4));
      end
      step();
    end
    checks++; if (bus.st_ready !== 1'b1 || empty !== 1'b1) begin errors++; $display("FAIL full_after st_ready=%b empty=%b required 1/1", bus.st_ready, empty); end
  endtask

  task automatic test_forward();
    bus.mem_busy = 1'b1;
    do_store(32'h20, 32'h1111);
    do_store(32'h20, 32'h2222);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 32'h20;
    #1;
    checks++; if (bus.ld_fwd !== 1'b1 || bus.ld_data !== 32'h2222) begin errors++; $display("FAIL fwd_youngest fwd=%b data=%h required 1/2222", bus.ld_fwd, bus.ld_data); end
    bus.ld_addr = 32'h22;
    #1;
    checks++; if (bus.ld_fwd !== 1'b1 || bus.ld_data !== 32'h2222) begin errors++; $display("FAIL fwd_subword fwd=%b data=%h required 1/2222", bus.ld_fwd, bus.ld_data); end
    bus.ld_addr = 32'h24;
    #1;
    checks++; if (bus.ld_fwd !== 1'b0 || bus.ld_data !== 32'hCAFE0009) begin errors++; $display("FAIL fwd_miss fwd=%b data=%h required 0/cafe0009", bus.ld_fwd, bus.ld_data); end
    checks++; if (bus.mem_address !== 32'h24) begin errors++; $display("FAIL fwd_miss_addr got %h required 00000024", bus.mem_address); end
    bus.ld_addr  = 32'h30;
    bus.st_valid = 1'b1;
    bus.st_addr  = 32'h30;
    bus.st_data  = 32'h3333;
    #1;
    checks++; if (bus.ld_fwd !== 1'b0 || bus.ld_data !== 32'hCAFE000C) begin errors++; $display("FAIL fwd_same_cycle fwd=%b data=%h required 0/cafe000c", bus.ld_fwd, bus.ld_data); end
    if (bus.st_ready === 1'b1) sb_q.push_back({32'h30, 32'h3333});
    step();
    bus.st_valid = 1'b0;
    #1;
    checks++; if (bus.ld_fwd !== 1'b1 || bus.ld_data !== 32'h3333) begin errors++; $display("FAIL fwd_next_cycle fwd=%b data=%h required 1/3333", bus.ld_fwd, bus.ld_data); end
    drain_all();
  endtask

  task automatic test_arbitration();
    do_store(32'h44, 32'hA5A5);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 32'h40;
    #1;
    checks++; if (bus.mem_we !== 1'b0 || bus.mem_address !== 32'h40) begin errors++; $display("FAIL arb_miss we=%b addr=%h required 0/00000040", bus.mem_we, bus.mem_address); end
    step();
    bus.ld_valid = 1'b0;
    #1;
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_address !== 32'h44) begin errors++; $display("FAIL arb_release we=%b addr=%h required 1/00000044", bus.mem_we, bus.mem_address); end
    step();
    do_store(32'h48, 32'hB6B6);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 32'h48;
    #1;
    checks++; if (bus.mem_we !== 1'b1 || bus.ld_fwd !== 1'b1 || bus.ld_data !== 32'hB6B6) begin errors++; $display("FAIL arb_hit we=%b fwd=%b data=%h required 1/1/b6b6", bus.mem_we, bus.ld_fwd, bus.ld_data); end
    step();
    bus.ld_valid = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL arb_empty got %b required 1", empty); end
  endtask

  task automatic test_wrap();
    int exp_cnt;
    int sent;
    logic enq, drn;
    exp_cnt = 0;
    sent    = 0;
    for (int cyc = 0; cyc < 100 && (sent < 10 || exp_cnt != 0); cyc++) begin
      bus.mem_busy = cyc[0];
      bus.st_valid = (sent < 10);
      bus.st_addr  = 32'h80 + 32'(sent * 4);
      bus.st_data  = 32'h5000 + 32'(sent);
      #1;
      checks++; if (count !== 3'(exp_cnt)) begin errors++; $display("FAIL wrap_count cyc%0d got %0d required %0d", cyc, count, exp_cnt); end
      checks++; if (bus.st_ready !== (exp_cnt != DEPTH)) begin errors++; $display("FAIL wrap_ready cyc%0d got %b required %b", cyc, bus.st_ready, exp_cnt != DEPTH); end
      enq = (sent < 10) && (exp_cnt != DEPTH);
      drn = (exp_cnt != 0) && !bus.mem_busy;
      if (enq) begin
        sb_q.push_back({bus.st_addr, bus.st_data});
        sent++;
      end
      exp_cnt = exp_cnt + int'(enq) - int'(drn);
      step();
    end
    bus.st_valid = 1'b0;
    bus.mem_busy = 1'b0;
    checks++; if (sent != 10 || empty !== 1'b1) begin errors++; $display("FAIL wrap_done sent=%0d empty=%b required 10/1", sent, empty); end
  endtask

  task automatic test_reset_mid();
    int w0;
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) do_store(32'hC0 + 32'(i * 4), 32'h7000 + 32'(i));
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL rmid_count got %0d required 3", count); end
    bus.mem_busy = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    checks++; if (count !== 3'd0 || bus.mem_we !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL rmid_async count=%0d we=%b empty=%b required 0/0/1", count, bus.mem_we, empty); end
    // The buffered stores were discarded, so no drain may follow.
    sb_q.delete();
    w0 = nwrites;
    step();
    reset = 1'b0;
    repeat (5) step();
    checks++; if (nwrites != w0) begin errors++; $display("FAIL rmid_writes got %0d required %0d", nwrites - w0, 0); end
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_full();
    test_forward();
    test_arbitration();
    test_wrap();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
